// File: rtl/vga_debug_overlay_if.sv
// Debug-bus inputs and VGA pin outputs of the overlay renderer.
// The slave side belongs to the renderer; the master side drives the taps and watches the pins.
interface vga_debug_overlay_if #(
  parameter int NUM_CH = 11,
  parameter int REG_W  = 16
);
  logic [NUM_CH*REG_W-1:0] channels;
  logic                    freeze;
  logic                    hsync;
  logic                    vsync;
  logic [2:0]              r;
  logic [2:0]              g;
  logic [2:0]              b;

  modport master (
    output channels,
    output freeze,
    input  hsync,
    input  vsync,
    input  r,
    input  g,
    input  b
  );

  modport slave (
    input  channels,
    input  freeze,
    output hsync,
    output vsync,
    output r,
    output g,
    output b
  );
endinterface

// File: rtl/vga_debug_overlay.sv
// VGA text overlay: per-frame snapshot of an N-channel debug bus rendered as hex rows,
// recently changed channels in red. Two pipeline stages after the raster counters.
module vga_debug_overlay #(
  parameter int NUM_CH       = 11,
  parameter int REG_W        = 16,
  parameter int ORIGIN_X     = 200,
  parameter int ORIGIN_Y     = 50,
  parameter int HOLD_FRAMES  = 30,
  parameter int H_VIS        = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int H_TOTAL      = 800,
  parameter int V_VIS        = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492,
  parameter int V_TOTAL      = 525
) (
  input  logic               clk,
  input  logic               rst,
  vga_debug_overlay_if.slave bus
);
  localparam int HW     = $clog2(H_TOTAL);
  localparam int VW     = $clog2(V_TOTAL);
  localparam int NDIG   = REG_W / 4;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [REG_W-1:0]  snap_q [NUM_CH];
  logic [REG_W-1:0]  snap_d [NUM_CH];
  logic [HOLD_W-1:0] hold_q [NUM_CH];
  logic [HOLD_W-1:0] hold_d [NUM_CH];
  logic              snap_evt;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == HW'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
    end
  end

  // Snapshot on the first pixel of vertical blanking so the visible text never tears.
  assign snap_evt = (h_q == '0) && (v_q == VW'(V_VIS));

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      snap_d[i] = snap_q[i];
      hold_d[i] = hold_q[i];
      if (snap_evt) begin
        if (!bus.freeze && (bus.channels[i*REG_W +: REG_W] != snap_q[i]))
          hold_d[i] = HOLD_W'(HOLD_FRAMES);
        else if (hold_q[i] != '0)
          hold_d[i] = hold_q[i] - 1'b1;
        if (!bus.freeze)
          snap_d[i] = bus.channels[i*REG_W +: REG_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_q[i] <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      for (int i = 0; i < NUM_CH; i++) begin
        snap_q[i] <= snap_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  logic [HW-1:0]    dx;
  logic [VW-1:0]    dy;
  logic             ch_ok, dig_ok, on_d, red_d, hs_d, vs_d;
  logic [REG_W-1:0] sel_val;
  logic [3:0]       nib_d;

  always_comb begin
    dx      = h_q - HW'(ORIGIN_X);
    dy      = v_q - VW'(ORIGIN_Y);
    ch_ok   = 1'b0;
    dig_ok  = 1'b0;
    red_d   = 1'b0;
    sel_val = '0;
    nib_d   = '0;
    if ((h_q < HW'(H_VIS)) && (v_q < VW'(V_VIS)) &&
        (h_q >= HW'(ORIGIN_X)) && (v_q >= VW'(ORIGIN_Y))) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ((dy >> 4) == VW'(i)) begin
          ch_ok   = 1'b1;
          sel_val = snap_q[i];
          red_d   = (hold_q[i] != '0);
        end
      end
      // Digit 0 is the most significant nibble.
      for (int k = 0; k < NDIG; k++) begin
        if ((dx >> 3) == HW'(k)) begin
          dig_ok = 1'b1;
          nib_d  = sel_val[(NDIG-1-k)*4 +: 4];
        end
      end
    end
    on_d = ch_ok && dig_ok;
    hs_d = !((h_q >= HW'(H_SYNC_START)) && (h_q < HW'(H_SYNC_END)));
    vs_d = !((v_q >= VW'(V_SYNC_START)) && (v_q < VW'(V_SYNC_END)));
  end

  logic       on1_q, red1_q, hs1_q, vs1_q;
  logic [3:0] nib1_q;
  logic [2:0] row1_q, col1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      on1_q  <= 1'b0;
      red1_q <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      nib1_q <= '0;
      row1_q <= '0;
      col1_q <= '0;
    end else begin
      on1_q  <= on_d;
      red1_q <= red_d;
      hs1_q  <= hs_d;
      vs1_q  <= vs_d;
      nib1_q <= nib_d;
      row1_q <= dy[3:1];
      col1_q <= dx[2:0];
    end
  end

  // 8x8 hex font, row 0 in the top byte, bit 7 = leftmost pixel.
  function automatic logic [63:0] glyph(input logic [3:0] n);
    case (n)
      4'h0:    glyph = 64'h3C666E7666663C00;
      4'h1:    glyph = 64'h1838181818187E00;
      4'h2:    glyph = 64'h3C66060C30607E00;
      4'h3:    glyph = 64'h3C66061C06663C00;
      4'h4:    glyph = 64'h0C1C3C6C7E0C0C00;
      4'h5:    glyph = 64'h7E607C0606663C00;
      4'h6:    glyph = 64'h3C60607C66663C00;
      4'h7:    glyph = 64'h7E060C1818181800;
      4'h8:    glyph = 64'h3C66663C66663C00;
      4'h9:    glyph = 64'h3C66663E060C3800;
      4'hA:    glyph = 64'h183C66667E666600;
      4'hB:    glyph = 64'h7C66667C66667C00;
      4'hC:    glyph = 64'h3C66606060663C00;
      4'hD:    glyph = 64'h786C6666666C7800;
      4'hE:    glyph = 64'h7E60607C60607E00;
      default: glyph = 64'h7E60607C60606000;
    endcase
  endfunction

  logic [63:0] gly;
  logic [7:0]  gly_row;
  logic        lit;

  always_comb begin
    gly     = glyph(nib1_q);
    gly_row = gly[{~row1_q, 3'b000} +: 8];
    lit     = on1_q && gly_row[~col1_q];
  end

  logic       hsync_q, vsync_q;
  logic [2:0] r_q, g_q, b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      hsync_q <= hs1_q;
      vsync_q <= vs1_q;
      r_q     <= lit ? 3'd7 : 3'd0;
      g_q     <= (lit && !red1_q) ? 3'd7 : 3'd0;
      b_q     <= (lit && !red1_q) ? 3'd7 : 3'd0;
    end
  end

  assign bus.hsync = hsync_q;
  assign bus.vsync = vsync_q;
  assign bus.r     = r_q;
  assign bus.g     = g_q;
  assign bus.b     = b_q;
endmodule

// File: tb/tb_vga_debug_overlay.sv
// Bench: a full-timing instance (reset, sync and glyph pins) and a shrunken-raster instance
// (snapshots, highlight, freeze, mid-frame reset) checked every cycle against a raster model.
module tb_vga_debug_overlay;
  localparam int F_B = 52 * 46;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #20 clk = ~clk;

  vga_debug_overlay_if #(.NUM_CH(11), .REG_W(16)) bus_a ();
  vga_debug_overlay_if #(.NUM_CH(2),  .REG_W(8))  bus_b ();

  vga_debug_overlay dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  vga_debug_overlay #(
    .NUM_CH(2), .REG_W(8), .ORIGIN_X(8), .ORIGIN_Y(4), .HOLD_FRAMES(3),
    .H_VIS(40), .H_SYNC_START(44), .H_SYNC_END(48), .H_TOTAL(52),
    .V_VIS(40), .V_SYNC_START(42), .V_SYNC_END(44), .V_TOTAL(46)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  // Raster description of each instance.
  int cfg_ht  [2] = '{800, 52};
  int cfg_vt  [2] = '{525, 46};
  int cfg_hv  [2] = '{640, 40};
  int cfg_vv  [2] = '{480, 40};
  int cfg_hss [2] = '{656, 44};
  int cfg_hse [2] = '{752, 48};
  int cfg_vss [2] = '{490, 42};
  int cfg_vse [2] = '{492, 44};
  int cfg_ox  [2] = '{200, 8};
  int cfg_oy  [2] = '{50, 4};
  int cfg_nch [2] = '{11, 2};
  int cfg_ndig[2] = '{4, 2};
  int cfg_hold[2] = '{30, 3};

  logic [63:0] glyphs [16] = '{
    64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00, 64'h3C66061C06663C00,
    64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00, 64'h3C60607C66663C00, 64'h7E060C1818181800,
    64'h3C66663C66663C00, 64'h3C66663E060C3800, 64'h183C66667E666600, 64'h7C66667C66667C00,
    64'h3C66606060663C00, 64'h786C6666666C7800, 64'h7E60607C60607E00, 64'h7E60607C60606000
  };

  int          pos [2];
  int          cyc [2];
  logic [15:0] m_snap [2][16];
  int          m_hold [2][16];
  logic [10:0] pipe1 [2];
  logic [10:0] expo  [2];
  logic        chk_on = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam logic [10:0] RST_EXP = {1'b1, 1'b1, 9'd0};

  function automatic logic [15:0] get_ch(input int id, input int i);
    if (id == 0) return bus_a.channels[i*16 +: 16];
    return {8'h00, bus_b.channels[i*8 +: 8]};
  endfunction

  // Expected {hsync, vsync, r, g, b} for raster position p, from the current model state.
  function automatic logic [10:0] pixel(input int id, input int p);
    int h, v, ch, d, nib, row, col;
    logic hs, vs;
    logic [8:0] rgb;
    logic [7:0] gr;
    h   = p % cfg_ht[id];
    v   = (p / cfg_ht[id]) % cfg_vt[id];
    hs  = !(h >= cfg_hss[id] && h < cfg_hse[id]);
    vs  = !(v >= cfg_vss[id] && v < cfg_vse[id]);
    rgb = 9'o000;
    if (h < cfg_hv[id] && v < cfg_vv[id] && h >= cfg_ox[id] && v >= cfg_oy[id]) begin
      ch = (v - cfg_oy[id]) / 16;
      d  = (h - cfg_ox[id]) / 8;
      if (ch < cfg_nch[id] && d < cfg_ndig[id]) begin
        nib = int'((m_snap[id][ch] >> (4 * (cfg_ndig[id] - 1 - d))) & 16'hF);
        row = ((v - cfg_oy[id]) % 16) / 2;
        col = (h - cfg_ox[id]) % 8;
        gr  = glyphs[nib][63 - 8*row -: 8];
        if (gr[7 - col]) rgb = (m_hold[id][ch] > 0) ? 9'o700 : 9'o777;
      end
    end
    return {hs, vs, rgb};
  endfunction

  // Model: advance one pixel per clock, expected output is the pixel from two clocks back.
  initial begin
    forever begin
      @(posedge clk);
      for (int id = 0; id < 2; id++) begin
        if ((id == 0) ? rst_a : rst_b) begin
          pos[id]   = 0;
          cyc[id]   = 0;
          pipe1[id] = RST_EXP;
          expo[id]  = RST_EXP;
          for (int i = 0; i < 16; i++) begin
            m_snap[id][i] = 16'h0;
            m_hold[id][i] = 0;
          end
          chk_on = 1'b1;
        end else begin
          logic fr;
          logic [15:0] nv;
          expo[id]  = pipe1[id];
          pipe1[id] = pixel(id, pos[id]);
          if (pos[id] == cfg_vv[id] * cfg_ht[id]) begin
            fr = (id == 0) ? bus_a.freeze : bus_b.freeze;
            for (int i = 0; i < cfg_nch[id]; i++) begin
              nv = get_ch(id, i);
              if (!fr && nv != m_snap[id][i]) m_hold[id][i] = cfg_hold[id];
              else if (m_hold[id][i] > 0)     m_hold[id][i] = m_hold[id][i] - 1;
              if (!fr) m_snap[id][i] = nv;
            end
          end
          pos[id] = (pos[id] + 1) % (cfg_ht[id] * cfg_vt[id]);
          cyc[id] = cyc[id] + 1;
        end
      end
    end
  end

  // Compare process, plus literal pins for the full-timing raster and the small vsync.
  always @(negedge clk) begin
    if (chk_on) begin
      logic [10:0] act_a, act_b;
      logic [7:0]  pat;
      int          k, fb;
      act_a = {bus_a.hsync, bus_a.vsync, bus_a.r, bus_a.g, bus_a.b};
      act_b = {bus_b.hsync, bus_b.vsync, bus_b.r, bus_b.g, bus_b.b};
      n_cmp++;
      if (act_a !== expo[0]) begin
        n_bad++;
        $display("FAIL pix_a cyc=%0d act=%h exp=%h", cyc[0], act_a, expo[0]);
      end
      n_cmp++;
      if (act_b !== expo[1]) begin
        n_bad++;
        $display("FAIL pix_b cyc=%0d act=%h exp=%h", cyc[1], act_b, expo[1]);
      end
      if (!rst_a && cyc[0] < 658) begin
        n_cmp++;
        if (act_a !== RST_EXP) begin
          n_bad++;
          $display("FAIL early_blank cyc=%0d act=%h exp=%h", cyc[0], act_a, RST_EXP);
        end
      end
      if (cyc[0] == 658 || cyc[0] == 753 || cyc[0] == 754) begin
        n_cmp++;
        if (bus_a.hsync !== (cyc[0] == 754)) begin
          n_bad++;
          $display("FAIL hsync_pin cyc=%0d act=%b exp=%b", cyc[0], bus_a.hsync, cyc[0] == 754);
        end
      end
      if (cyc[0] >= 40201 && cyc[0] <= 40209) begin
        pat = 8'h3C;
        k   = cyc[0] - 40202;
        n_cmp++;
        if (k < 0) begin
          if ({bus_a.r, bus_a.g, bus_a.b} !== 9'o000) begin
            n_bad++;
            $display("FAIL glyph_left cyc=%0d act=%o exp=000", cyc[0], {bus_a.r, bus_a.g, bus_a.b});
          end
        end else if ({bus_a.r, bus_a.g, bus_a.b} !== (pat[7 - k] ? 9'o777 : 9'o000)) begin
          n_bad++;
          $display("FAIL glyph0_row0 k=%0d act=%o exp=%o", k, {bus_a.r, bus_a.g, bus_a.b},
                   pat[7 - k] ? 9'o777 : 9'o000);
        end
      end
      fb = cyc[1] % F_B;
      if (cyc[1] >= 2 && (fb == 2185 || fb == 2186 || fb == 2289 || fb == 2290)) begin
        n_cmp++;
        if (bus_b.vsync !== (fb == 2185 || fb == 2290)) begin
          n_bad++;
          $display("FAIL vsync_pin cyc=%0d act=%b exp=%b", cyc[1], bus_b.vsync, fb == 2185 || fb == 2290);
        end
      end
    end
  end

  task automatic step(input int n);
    for (int t = 0; t < n; t++) @(negedge clk);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.channels = '0;
    bus_a.freeze   = 1'b0;
    bus_b.channels = '0;
    bus_b.freeze   = 1'b0;
    step(3);
    rst_a = 1'b0;
    rst_b = 1'b0;
    $display("phase reset released");

    for (int t = 0; t < 8 * F_B; t++) begin
      @(negedge clk);
      if ($urandom_range(0, 1999) == 0) bus_b.channels = 16'($urandom);
      if ($urandom_range(0, 4999) == 0) bus_b.freeze = ~bus_b.freeze;
      if ($urandom_range(0, 999) == 0)
        for (int i = 0; i < 11; i++) bus_a.channels[i*16 +: 16] = 16'($urandom);
    end
    $display("phase random traffic done cyc_b=%0d", cyc[1]);

    bus_b.freeze = 1'b1;
    bus_b.channels[7:0] = ~bus_b.channels[7:0];
    step(3 * F_B);
    bus_b.channels[7:0] = 8'hFF;
    bus_b.freeze = 1'b0;
    step(2 * F_B);
    $display("phase freeze/unfreeze done");

    bus_b.channels = bus_b.channels ^ 16'h5A3C;
    step(F_B);
    begin
      bit found;
      found = 1'b0;
      for (int t = 0; t < F_B && !found; t++) begin
        @(negedge clk);
        if (pos[1] / 52 == 20) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
        n_bad++;
        $display("FAIL wait_line20 act=timeout exp=line20");
      end
    end
    rst_b = 1'b1;
    step(1);
    rst_b = 1'b0;
    step(2 * F_B);
    $display("phase mid-frame reset done");

    while (cyc[0] < 47000) step(1);
    $display("phase full-timing rows done cyc_a=%0d", cyc[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
